// File: rtl/addsub_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addsub_seq_pkg : shared types and helpers for addsub_seq            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package addsub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Operands are walked in whole slices only, so WIDTH must split evenly.
    function automatic bit chunk_legal(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addsub_seq_if : operand/result valid-ready bundle for addsub_seq    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface addsub_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             ovf;
    logic             cout;
    logic             zero;

    modport master (
        output in_valid, op_sub, a, b, out_ready,
        input  in_ready, out_valid, s, ovf, cout, zero
    );

    modport slave (
        input  in_valid, op_sub, a, b, out_ready,
        output in_ready, out_valid, s, ovf, cout, zero
    );
endinterface
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addsub_slice : combinational CHUNK-bit add/invert slice             |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module addsub_slice #(
    parameter int CHUNK = 4
) (
    input  wire logic [CHUNK-1:0] i_a,
    input  wire logic [CHUNK-1:0] i_b,
    input  wire logic             i_cin,
    input  wire logic             i_invert,
    output logic      [CHUNK-1:0] o_sum,
    output logic                  o_cout,
    output logic                  o_cmsb
);
    logic [CHUNK-1:0] w_b;
    logic [CHUNK:0]   w_full;

    assign w_b    = i_invert ? ~i_b : i_b;
    assign w_full = {1'b0, i_a} + {1'b0, w_b} + {{CHUNK{1'b0}}, i_cin};
    assign o_sum  = w_full[CHUNK-1:0];
    assign o_cout = w_full[CHUNK];
    // Sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out directly.
    assign o_cmsb = w_full[CHUNK-1] ^ i_a[CHUNK-1] ^ w_b[CHUNK-1];
endmodule
`default_nettype wire

// File: rtl/addsub_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addsub_seq : chunk-serial WIDTH-bit adder/subtractor, valid/ready   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module addsub_seq
    import addsub_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    addsub_seq_if.slave bus
);
    localparam int NCH  = nch(WIDTH, CHUNK);
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    generate
        if (!chunk_legal(WIDTH, CHUNK)) begin : g_bad_chunk
            $error("addsub_seq: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_sub;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_ovf;
    logic             r_cout;
    logic             r_zero;

    logic [BW-1:0]    w_base;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_cmsb;
    logic             w_last;
    logic [WIDTH-1:0] w_s_next;

    assign w_base = BW'(r_idx * CHUNK);
    assign w_last = (r_idx == IDXW'(NCH - 1));

    // B is held raw; the slice applies the inversion for subtract.
    addsub_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .i_a      (r_a[w_base +: CHUNK]),
        .i_b      (r_b[w_base +: CHUNK]),
        .i_cin    (r_carry),
        .i_invert (r_sub),
        .o_sum    (w_sum),
        .o_cout   (w_cout),
        .o_cmsb   (w_cmsb)
    );

    always_comb begin
        w_s_next                   = r_s;
        w_s_next[w_base +: CHUNK]  = w_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= '0;
            r_sub       <= 1'b0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_cout      <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_sub      <= bus.op_sub;
                        r_carry    <= bus.op_sub;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    r_s     <= w_s_next;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_ovf       <= w_cmsb ^ w_cout;
                        r_cout      <= w_cout;
                        r_zero      <= (w_s_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.s         = r_s;
    assign bus.ovf       = r_ovf;
    assign bus.cout      = r_cout;
    assign bus.zero      = r_zero;
endmodule
`default_nettype wire
